// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared CPU definitions.
//
// Holds the opcode constants used by decode plus the register bank sizing
// (DW, AW, NREG), the R0 index and the register bank FSM state encoding.
// No ports; imported with "import cpu_pkg::*;".

package cpu_pkg;

  // Existing opcode constants (4-bit major opcode field).
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_STOR = 4'h9;
  localparam logic [3:0] OP_BR   = 4'hC;

  // Register bank sizing.
  localparam int DW     = 16;       // data width
  localparam int AW     = 5;        // register address width
  localparam int NREG   = 2 ** AW;  // register count
  localparam int R0_IDX = 0;        // hard-wired zero register

  // Register bank operand-read FSM. Encoding 3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    RB_IDLE  = 2'd0,
    RB_WAIT  = 2'd1,
    RB_VALID = 2'd2
  } rb_state_t;

endpackage

// File: rtl/register_bank_scoreboard.sv
// register_bank_scoreboard -- pending-write tracking for the register bank.
//
// Keeps one pending bit per register. Decode sets a bit when it reserves a
// destination; write-back clears it. When both hit the same register in the
// same cycle the reservation wins (a newer writer is already in flight).
// R0 is never marked pending.
//
// Hazard rule for a source register in the current cycle:
//   REGISTER_BANK_BYPASS_EN defined : pending and not being written back now
//                                     (the write-back value is forwarded).
//   REGISTER_BANK_BYPASS_EN undefined: pending, or being written back now
//                                     (read it from storage next cycle).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wb_cond, wb_addr    write-back commit and destination
//   res_en, res_addr    decode reservation and destination
//   src_a, src_b        source registers being checked this cycle
//   hit_a, hit_b        source is the target of this cycle's write-back
//   hazard              at least one source must wait

module register_bank_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW   = cpu_pkg::AW,
  parameter int NREG = cpu_pkg::NREG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_cond,
  input  logic [AW-1:0] wb_addr,
  input  logic          res_en,
  input  logic [AW-1:0] res_addr,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  output logic          hit_a,
  output logic          hit_b,
  output logic          hazard
);

  logic [NREG-1:0] pending;
  logic            wb_ok;
  logic            res_ok;
  logic            busy_a;
  logic            busy_b;

  assign wb_ok  = wb_cond && (wb_addr  != AW'(R0_IDX));
  assign res_ok = res_en  && (res_addr != AW'(R0_IDX));

  // The set follows the clear so that the reservation wins on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wb_ok)  pending[wb_addr]  <= 1'b0;
      if (res_ok) pending[res_addr] <= 1'b1;
    end
  end

  // wb_ok already excludes R0, so R0 never reports a hit.
  assign hit_a = wb_ok && (wb_addr == src_a);
  assign hit_b = wb_ok && (wb_addr == src_b);

`ifdef REGISTER_BANK_BYPASS_EN
  assign busy_a = pending[src_a] && !hit_a;
  assign busy_b = pending[src_b] && !hit_b;
`else
  assign busy_a = pending[src_a] || hit_a;
  assign busy_b = pending[src_b] || hit_b;
`endif

  assign hazard = busy_a || busy_b;

endmodule

// File: rtl/register_bank.sv
// register_bank -- NREG x DW register file with hazard-checked operand reads.
//
// Storage: R1..R(NREG-1) are flops written by the write-back stage; R0 reads
// zero and ignores writes and reservations. Pending bits live in
// register_bank_scoreboard.
//
// Operand read handshake: RD_EN is a request sampled on every rising edge in
// IDLE or VALID (ignored in WAIT). A hazard-free request captures both
// operands at that edge and RD_VALID is high for exactly the following cycle
// with RD_DATA_A/B valid. A request with a hazard latches its source
// addresses, RD_WAIT stays high while it is stalled, and it completes with a
// RD_VALID pulse once no latched source is pending. There is no back-pressure
// on RD_VALID; RD_DATA_A/B hold their last captured values.
//
// Optional feature: define REGISTER_BANK_BYPASS_EN to forward a same-cycle
// write-back directly into the captured operand instead of stalling.
//
// Ports:
//   CLK, RST               clock, asynchronous active-high reset
//   WB_DATA/WB_ADDR/WB_COND write-back data, destination, commit
//   RES_EN/RES_ADDR        destination reservation from decode
//   RD_EN, RD_ADDR_A/B     operand read request and source registers
//   RD_DATA_A/B            registered operands
//   RD_VALID, RD_WAIT      operands valid pulse / request stalled
//   STATE_DBG              current FSM state (debug)

module register_bank
  import cpu_pkg::*;
#(
  parameter int DW   = cpu_pkg::DW,
  parameter int AW   = cpu_pkg::AW,
  parameter int NREG = cpu_pkg::NREG
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] WB_DATA,
  input  logic [AW-1:0] WB_ADDR,
  input  logic          WB_COND,
  input  logic          RES_EN,
  input  logic [AW-1:0] RES_ADDR,
  input  logic          RD_EN,
  input  logic [AW-1:0] RD_ADDR_A,
  input  logic [AW-1:0] RD_ADDR_B,
  output logic [DW-1:0] RD_DATA_A,
  output logic [DW-1:0] RD_DATA_B,
  output logic          RD_VALID,
  output logic          RD_WAIT,
  output logic [1:0]    STATE_DBG
);

  logic [DW-1:0] regs [NREG];

  rb_state_t     state;
  rb_state_t     state_nxt;
  logic          capture;
  logic          latch_src;

  logic [AW-1:0] lat_a;
  logic [AW-1:0] lat_b;
  logic [AW-1:0] src_a;
  logic [AW-1:0] src_b;
  logic          hit_a;
  logic          hit_b;
  logic          hazard;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;

  // ---------------- storage ----------------
  // regs[0] is reset to zero and never written, so it always reads zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (WB_COND && (WB_ADDR != AW'(R0_IDX))) begin
      regs[WB_ADDR] <= WB_DATA;
    end
  end

  // ---------------- hazard tracking ----------------
  // A stalled request checks its latched sources; otherwise the live ones.
  assign src_a = (state == RB_WAIT) ? lat_a : RD_ADDR_A;
  assign src_b = (state == RB_WAIT) ? lat_b : RD_ADDR_B;

  register_bank_scoreboard #(
    .AW   (AW),
    .NREG (NREG)
  ) u_scoreboard (
    .clk      (CLK),
    .rst      (RST),
    .wb_cond  (WB_COND),
    .wb_addr  (WB_ADDR),
    .res_en   (RES_EN),
    .res_addr (RES_ADDR),
    .src_a    (src_a),
    .src_b    (src_b),
    .hit_a    (hit_a),
    .hit_b    (hit_b),
    .hazard   (hazard)
  );

  // Forward mux. Without bypass a hit always raises hazard, so capture never
  // happens while a hit is active and the mux reduces to the storage read.
  assign opnd_a = hit_a ? WB_DATA : regs[src_a];
  assign opnd_b = hit_b ? WB_DATA : regs[src_b];

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    latch_src = 1'b0;
    case (state)
      RB_IDLE, RB_VALID: begin
        if (RD_EN) begin
          if (hazard) begin
            state_nxt = RB_WAIT;
            latch_src = 1'b1;
          end else begin
            state_nxt = RB_VALID;
            capture   = 1'b1;
          end
        end else begin
          state_nxt = RB_IDLE;
        end
      end
      RB_WAIT: begin
        if (!hazard) begin
          state_nxt = RB_VALID;
          capture   = 1'b1;
        end
      end
      default: state_nxt = RB_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lat_a <= '0;
      lat_b <= '0;
    end else if (latch_src) begin
      lat_a <= RD_ADDR_A;
      lat_b <= RD_ADDR_B;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_DATA_A <= '0;
      RD_DATA_B <= '0;
    end else if (capture) begin
      RD_DATA_A <= opnd_a;
      RD_DATA_B <= opnd_b;
    end
  end

  assign RD_VALID  = (state == RB_VALID);
  assign RD_WAIT   = (state == RB_WAIT);
  assign STATE_DBG = state;

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank -- directed self-checking bench for register_bank.
// Inputs change 1 ns after the rising edge; outputs are sampled there too,
// so each check sees the state produced by the preceding edge.

module tb_register_bank;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] WB_DATA;
  logic [4:0]  WB_ADDR;
  logic        WB_COND;
  logic        RES_EN;
  logic [4:0]  RES_ADDR;
  logic        RD_EN;
  logic [4:0]  RD_ADDR_A;
  logic [4:0]  RD_ADDR_B;
  logic [15:0] RD_DATA_A;
  logic [15:0] RD_DATA_B;
  logic        RD_VALID;
  logic        RD_WAIT;
  logic [1:0]  STATE_DBG;

  int checks   = 0;
  int failures = 0;
  int n_wait;

  logic [15:0] exp_q[$];
  logic [15:0] exp_a;
  logic [15:0] exp_b;

`ifdef REGISTER_BANK_BYPASS_EN
  localparam int EXP_WAIT_031 = 3;
`else
  localparam int EXP_WAIT_031 = 4;
`endif

  register_bank dut (
    .CLK       (CLK),
    .RST       (RST),
    .WB_DATA   (WB_DATA),
    .WB_ADDR   (WB_ADDR),
    .WB_COND   (WB_COND),
    .RES_EN    (RES_EN),
    .RES_ADDR  (RES_ADDR),
    .RD_EN     (RD_EN),
    .RD_ADDR_A (RD_ADDR_A),
    .RD_ADDR_B (RD_ADDR_B),
    .RD_DATA_A (RD_DATA_A),
    .RD_DATA_B (RD_DATA_B),
    .RD_VALID  (RD_VALID),
    .RD_WAIT   (RD_WAIT),
    .STATE_DBG (STATE_DBG)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [15:0] d);
    WB_COND = en;
    WB_ADDR = a;
    WB_DATA = d;
  endtask

  task automatic res(input logic en, input logic [4:0] a);
    RES_EN   = en;
    RES_ADDR = a;
  endtask

  task automatic rd(input logic en, input logic [4:0] a, input logic [4:0] b);
    RD_EN     = en;
    RD_ADDR_A = a;
    RD_ADDR_B = b;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h want 0x%04h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1;
    wb(1'b0, 5'd0, 16'h0);
    res(1'b0, 5'd0);
    rd(1'b0, 5'd0, 5'd0);
    tick();
    tick();
    chk("rst_valid", 16'(RD_VALID), 16'h0);
    chk("rst_wait",  16'(RD_WAIT),  16'h0);
    chk("rst_state", 16'(STATE_DBG), 16'h0);
    chk("rst_data_a", RD_DATA_A, 16'h0);
    RST = 1'b0;
    tick();

    // Write R3, read A=3 B=0 next cycle.
    wb(1'b1, 5'd3, 16'h1234);
    tick();
    wb(1'b0, 5'd0, 16'h0);
    rd(1'b1, 5'd3, 5'd0);
    tick();
    rd(1'b0, 5'd0, 5'd0);
    chk("t030_valid", 16'(RD_VALID), 16'h1);
    chk("t030_state", 16'(STATE_DBG), 16'h2);
    chk("t030_a", RD_DATA_A, 16'h1234);
    chk("t030_b", RD_DATA_B, 16'h0000);
    tick();
    chk("t030_pulse_end", 16'(RD_VALID), 16'h0);
    chk("t030_hold_a", RD_DATA_A, 16'h1234);

    // Reserve R5, read it, write back 3 cycles after the request.
    res(1'b1, 5'd5);
    tick();
    res(1'b0, 5'd0);
    rd(1'b1, 5'd5, 5'd0);
    tick();
    rd(1'b0, 5'd0, 5'd0);
    chk("t031_enter_wait", 16'(RD_WAIT), 16'h1);
    n_wait = 0;
    for (int c = 2; c < 12 && !RD_VALID; c++) begin
      if (RD_WAIT) n_wait++;
      if (c == 4) wb(1'b1, 5'd5, 16'hBEEF);
      else        wb(1'b0, 5'd0, 16'h0);
      tick();
    end
    wb(1'b0, 5'd0, 16'h0);
    chk("t031_wait_cycles", 16'(n_wait), 16'(EXP_WAIT_031));
    chk("t031_valid", 16'(RD_VALID), 16'h1);
    chk("t031_a", RD_DATA_A, 16'hBEEF);
    tick();

    // R0: write and reserve are ignored.
    wb(1'b1, 5'd0, 16'hFFFF);
    res(1'b1, 5'd0);
    tick();
    wb(1'b0, 5'd0, 16'h0);
    res(1'b0, 5'd0);
    rd(1'b1, 5'd0, 5'd0);
    tick();
    rd(1'b0, 5'd0, 5'd0);
    chk("t032_wait", 16'(RD_WAIT), 16'h0);
    chk("t032_valid", 16'(RD_VALID), 16'h1);
    chk("t032_a", RD_DATA_A, 16'h0000);
    tick();

    // Same-cycle write-back and reserve of R7: reservation wins.
    wb(1'b1, 5'd7, 16'h0001);
    res(1'b1, 5'd7);
    tick();
    wb(1'b0, 5'd0, 16'h0);
    res(1'b0, 5'd0);
    rd(1'b1, 5'd7, 5'd0);
    tick();
    rd(1'b0, 5'd0, 5'd0);
    chk("t033_wait0", 16'(RD_WAIT), 16'h1);
    tick();
    tick();
    tick();
    chk("t033_wait3", 16'(RD_WAIT), 16'h1);
    chk("t033_no_valid", 16'(RD_VALID), 16'h0);
    wb(1'b1, 5'd7, 16'h0002);
    tick();
    wb(1'b0, 5'd0, 16'h0);
    for (int c = 0; c < 4 && !RD_VALID; c++) tick();
    chk("t033_valid", 16'(RD_VALID), 16'h1);
    chk("t033_a", RD_DATA_A, 16'h0002);
    tick();

    // Back-to-back hazard-free reads.
    wb(1'b1, 5'd1, 16'h1111); tick();
    wb(1'b1, 5'd2, 16'h2222); tick();
    wb(1'b1, 5'd4, 16'h4444); tick();
    wb(1'b0, 5'd0, 16'h0);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    exp_q.push_back(16'h2222); exp_q.push_back(16'h4444);
    exp_q.push_back(16'h4444); exp_q.push_back(16'h1111);
    rd(1'b1, 5'd1, 5'd2); tick();
    rd(1'b1, 5'd2, 5'd4);
    exp_a = exp_q.pop_front(); exp_b = exp_q.pop_front();
    chk("t034_v0", 16'(RD_VALID), 16'h1);
    chk("t034_a0", RD_DATA_A, exp_a);
    chk("t034_b0", RD_DATA_B, exp_b);
    tick();
    rd(1'b1, 5'd4, 5'd1);
    exp_a = exp_q.pop_front(); exp_b = exp_q.pop_front();
    chk("t034_v1", 16'(RD_VALID), 16'h1);
    chk("t034_a1", RD_DATA_A, exp_a);
    chk("t034_b1", RD_DATA_B, exp_b);
    tick();
    rd(1'b0, 5'd0, 5'd0);
    exp_a = exp_q.pop_front(); exp_b = exp_q.pop_front();
    chk("t034_v2", 16'(RD_VALID), 16'h1);
    chk("t034_a2", RD_DATA_A, exp_a);
    chk("t034_b2", RD_DATA_B, exp_b);
    tick();
    chk("t034_end", 16'(RD_VALID), 16'h0);

    // Reset during WAIT.
    res(1'b1, 5'd9);
    tick();
    res(1'b0, 5'd0);
    rd(1'b1, 5'd0, 5'd9);
    tick();
    rd(1'b0, 5'd0, 5'd0);
    chk("t035_wait", 16'(RD_WAIT), 16'h1);
    #2 RST = 1'b1;
    #1;
    chk("t035_rst_wait", 16'(RD_WAIT), 16'h0);
    chk("t035_rst_state", 16'(STATE_DBG), 16'h0);
    chk("t035_rst_a", RD_DATA_A, 16'h0);
    chk("t035_rst_b", RD_DATA_B, 16'h0);
    tick();
    RST = 1'b0;
    tick();
    tick();
    tick();
    chk("t035_no_valid", 16'(RD_VALID), 16'h0);
    chk("t035_no_wait", 16'(RD_WAIT), 16'h0);
    // Storage and pending bits were cleared by reset.
    rd(1'b1, 5'd1, 5'd9);
    tick();
    rd(1'b0, 5'd0, 5'd0);
    chk("t035_post_valid", 16'(RD_VALID), 16'h1);
    chk("t035_post_a", RD_DATA_A, 16'h0000);
    chk("t035_post_b", RD_DATA_B, 16'h0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
